// File: rtl/clk_div_n.sv
// Parametrised integer clock divider with a period-start strobe, phase output and
// glitch-free runtime ratio changes. Define CLK_DIV_N_LOCK_SYNC_EN to synchronise en_i.
module clk_div_n #(
  parameter int CNT_W       = 4,
  parameter int DIV_DEFAULT = 5
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic             en_i,
  input  logic [CNT_W-1:0] div_i,
  input  logic             div_load_i,
  output logic             div_busy_o,
  output logic             clk_o,
  output logic             ce_o,
  output logic [CNT_W-1:0] phase_o,
  output logic             active_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] DIV_RST = CNT_W'(DIV_DEFAULT);
  localparam logic [CNT_W-1:0] DIV_MIN = CNT_W'(2);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pos_hi_q, pos_hi_d;
  logic             neg_hi_q;
  logic             ce_q, ce_d;
  logic [CNT_W-1:0] div_q, div_d;
  logic [CNT_W-1:0] pend_q, pend_d;
  logic             busy_q, busy_d;

  logic             en_s;
  logic             wrap;
  logic [CNT_W-1:0] cnt_nxt;
  logic [CNT_W-1:0] half_n;
  logic [CNT_W-1:0] div_clamped;

`ifdef CLK_DIV_N_LOCK_SYNC_EN
  // Two-flop synchroniser lets en_i come straight from an asynchronous PLL lock.
  logic [1:0] en_sync_q;

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      en_sync_q <= 2'b00;
    end else begin
      en_sync_q <= {en_sync_q[0], en_i};
    end
  end

  assign en_s = en_sync_q[1];
`else
  assign en_s = en_i;
`endif

  assign wrap        = (cnt_q == (div_q - 1'b1));
  assign cnt_nxt     = wrap ? '0 : cnt_q + 1'b1;
  assign half_n      = div_q >> 1;
  assign div_clamped = (div_i < DIV_MIN) ? DIV_MIN : div_i;

  // NOTE: every variable gets a default at the top of the block so that no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d  = state_q;
    cnt_d    = '0;
    pos_hi_d = 1'b0;
    ce_d     = 1'b0;

    unique case (state_q)
      IDLE:    if (en_s) state_d = RUN;
      RUN:     if (!en_s) state_d = DRAIN;
      DRAIN: begin
        if (en_s) begin
          state_d = RUN;
        end else if (wrap) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Leaving IDLE starts a fresh period; otherwise the count simply continues,
    // so a DRAIN->RUN return never disturbs the phase.
    if (state_d != IDLE) begin
      cnt_d    = (state_q == IDLE) ? '0 : cnt_nxt;
      pos_hi_d = (cnt_d < half_n);
      ce_d     = (cnt_d == '0);
    end
  end

  // Pending ratio is only swapped in at a period boundary (or at once when idle);
  // a load accepted in a wrap cycle therefore waits for the following wrap.
  always_comb begin
    div_d  = div_q;
    pend_d = pend_q;
    busy_d = busy_q;

    if (!busy_q && div_load_i) begin
      pend_d = div_clamped;
      busy_d = 1'b1;
    end else if (busy_q && ((state_q == IDLE) || wrap)) begin
      div_d  = pend_q;
      busy_d = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      pos_hi_q <= 1'b0;
      ce_q     <= 1'b0;
      div_q    <= DIV_RST;
      pend_q   <= DIV_RST;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      pos_hi_q <= pos_hi_d;
      ce_q     <= ce_d;
      div_q    <= div_d;
      pend_q   <= pend_d;
      busy_q   <= busy_d;
    end
  end

  // Half-cycle extension of the high time for odd ratios.
  always_ff @(negedge clk_i) begin
    if (!rstn_i) begin
      neg_hi_q <= 1'b0;
    end else begin
      neg_hi_q <= pos_hi_q;
    end
  end

  // neg_hi_q is always low when the ratio or state changes in normal operation, so
  // the OR cannot glitch; the IDLE gate only matters right after a mid-period reset.
  assign clk_o      = pos_hi_q | (neg_hi_q & div_q[0] & (state_q != IDLE));
  assign ce_o       = ce_q;
  assign phase_o    = cnt_q;
  assign active_o   = (state_q != IDLE);
  assign div_busy_o = busy_q;

endmodule
